// File: rtl/rtc_bus_sequencer.sv
// Purpose: round-robin arbiter and phase sequencer for the external RTC multiplexed address/data bus.
// Latency: grant edge -> strobes next cycle; ack on first GAP2 cycle (1+2*T_PULSE+T_GAP after grant), 25-cycle occupancy.
// Backpressure: requests are levels held until ack; a request seen while busy waits for IDLE, no preemption.
module rtc_bus_sequencer #(
    parameter int T_PULSE = 8,
    parameter int T_GAP   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       ChipSelect,
    output logic       Read,
    output logic       Write,
    output logic       AoD,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_GAP1 = 3'd2,
        S_DATA = 3'd3,
        S_GAP2 = 3'd4
    } state_t;

    // Counter reload values: a phase lasts (reload + 1) cycles.
    localparam logic [3:0] PULSE_LD = 4'(T_PULSE - 1);
    localparam logic [3:0] GAP_LD   = 4'(T_GAP - 1);

    state_t     state, nxt_state;
    logic [3:0] cnt;
    logic       last;
    logic       gnt_q, we_q;
    logic [7:0] addr_q, wdata_q;

    logic       gnt_win;
    logic       sel_gnt, sel_we;
    logic [7:0] sel_addr, sel_wdata;
    logic       entering;

    logic       cs_d, rd_d, wr_d, aod_d, oe_d, busy_d, ack0_d, ack1_d;
    logic [7:0] bus_out_d;

    // Arbitration and selection of the access fields: the winner's inputs while
    // granting in IDLE (not yet latched), the latched copy for the rest of the access.
    always_comb begin
        gnt_win = (req0 && req1) ? ~last : req1;
        if (state == S_IDLE) begin
            sel_gnt   = gnt_win;
            sel_we    = gnt_win ? we1    : we0;
            sel_addr  = gnt_win ? addr1  : addr0;
            sel_wdata = gnt_win ? wdata1 : wdata0;
        end else begin
            sel_gnt   = gnt_q;
            sel_we    = we_q;
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
        end
    end

    // State register, phase counter and grant bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            last    <= 1'b1;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
        end else begin
            state <= nxt_state;
            if (nxt_state != state) begin
                case (nxt_state)
                    S_ADDR, S_DATA: cnt <= PULSE_LD;
                    S_GAP1, S_GAP2: cnt <= GAP_LD;
                    default:        cnt <= 4'd0;
                endcase
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == S_IDLE && (req0 || req1)) begin
                gnt_q   <= sel_gnt;
                last    <= sel_gnt;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end

    // Next-state: each phase runs until its counter reaches zero.
    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE: if (req0 || req1) nxt_state = S_ADDR;
            S_ADDR: if (cnt == 4'd0)  nxt_state = S_GAP1;
            S_GAP1: if (cnt == 4'd0)  nxt_state = S_DATA;
            S_DATA: if (cnt == 4'd0)  nxt_state = S_GAP2;
            S_GAP2: if (cnt == 4'd0)  nxt_state = S_IDLE;
            default:                  nxt_state = S_IDLE;
        endcase
    end

    // Output decode from the state being entered, so registered pins line up with the state.
    always_comb begin
        entering  = (nxt_state != state);
        cs_d      = 1'b1;
        rd_d      = 1'b1;
        wr_d      = 1'b1;
        aod_d     = 1'b1;
        oe_d      = 1'b0;
        bus_out_d = bus_out;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        busy_d    = (nxt_state != S_IDLE);
        case (nxt_state)
            S_ADDR: begin
                cs_d      = 1'b0;
                wr_d      = 1'b0;
                aod_d     = 1'b0;
                oe_d      = 1'b1;
                bus_out_d = sel_addr;
            end
            S_GAP1: begin
                aod_d     = 1'b0;
                oe_d      = entering;   // hold the address one cycle past the strobe
                bus_out_d = sel_addr;
            end
            S_DATA: begin
                cs_d = 1'b0;
                if (sel_we) begin
                    wr_d      = 1'b0;
                    oe_d      = 1'b1;
                    bus_out_d = sel_wdata;
                end else begin
                    rd_d = 1'b0;
                end
            end
            S_GAP2: begin
                oe_d   = sel_we && entering;
                ack0_d = entering && !sel_gnt;
                ack1_d = entering && sel_gnt;
                if (sel_we) bus_out_d = sel_wdata;
            end
            default: ;
        endcase
    end

    // Output registers; read data is captured on the last DATA cycle of a read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ChipSelect <= 1'b1;
            Read       <= 1'b1;
            Write      <= 1'b1;
            AoD        <= 1'b1;
            bus_oe     <= 1'b0;
            bus_out    <= 8'd0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            rdata      <= 8'd0;
        end else begin
            ChipSelect <= cs_d;
            Read       <= rd_d;
            Write      <= wr_d;
            AoD        <= aod_d;
            bus_oe     <= oe_d;
            bus_out    <= bus_out_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            busy       <= busy_d;
            if (state == S_DATA && nxt_state == S_GAP2 && !we_q) rdata <= bus_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: cycle-by-cycle pin checks against a timing model,
// a small RTC memory model on the bus, and a scoreboard of expected acks/read data.
module tb_rtc_bus_sequencer;

    localparam int TP     = 8;
    localparam int TG     = 4;
    localparam int ACK_N  = 2*TP + TG + 1;   // first GAP2 cycle, counted from the grant edge
    localparam int OCC    = 2*TP + 2*TG + 1; // cycle count up to and including the return to IDLE

    logic       clk;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1, busy;
    logic [7:0] rdata;
    logic       ChipSelect, Read, Write, AoD;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;

    typedef struct packed {
        logic       port;
        logic [7:0] rdata;
    } exp_t;

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] model_rdata = 8'h00;

    logic [7:0] rtc_mem [256];
    logic [7:0] rtc_addr;

    rtc_bus_sequencer #(.T_PULSE(TP), .T_GAP(TG)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .we0        (we0),
        .addr0      (addr0),
        .wdata0     (wdata0),
        .req1       (req1),
        .we1        (we1),
        .addr1      (addr1),
        .wdata1     (wdata1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata      (rdata),
        .busy       (busy),
        .ChipSelect (ChipSelect),
        .Read       (Read),
        .Write      (Write),
        .AoD        (AoD),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .bus_in     (bus_in)
    );

    // Tristate resolution as done at the top level; the RTC drives when the FPGA does not.
    assign bus_in = bus_oe ? bus_out : rtc_mem[rtc_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RTC model: latches the address on the address strobe, stores data on a data-phase write.
    initial begin
        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;
        rtc_mem[8'h22] = 8'h59;
        rtc_addr = 8'h00;
        forever begin
            @(negedge clk);
            if (!ChipSelect && !Write && !AoD && bus_oe) rtc_addr = bus_out;
            if (!ChipSelect && !Write && AoD && bus_oe) rtc_mem[rtc_addr] = bus_out;
        end
    end

    // Scoreboard: every ack must match the next expected port and read data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack0 || ack1) begin
                vectors++;
                if (ack0 && ack1) begin
                    miscompares++;
                    $display("FAIL ack_overlap got ack0=%b ack1=%b required one at a time", ack0, ack1);
                end else if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_ack got ack0=%b ack1=%b required none", ack0, ack1);
                end else begin
                    e = sb.pop_front();
                    if (ack1 !== e.port || rdata !== e.rdata) begin
                        miscompares++;
                        $display("FAIL ack_data got port=%0d rdata=%h required port=%0d rdata=%h",
                                 ack1, rdata, e.port, e.rdata);
                    end
                end
            end
        end
    end

    // Expected {ChipSelect,Read,Write,AoD,bus_oe,busy,ack0,ack1} n cycles after the grant edge.
    function automatic logic [7:0] exp_sig(input int n, input logic we, input logic port);
        logic cs, rd, wr, aod, oe, bsy, a0, a1;
        cs = 1'b1; rd = 1'b1; wr = 1'b1; aod = 1'b1; oe = 1'b0; bsy = 1'b1; a0 = 1'b0; a1 = 1'b0;
        if (n <= TP) begin
            cs = 1'b0; wr = 1'b0; aod = 1'b0; oe = 1'b1;
        end else if (n <= TP + TG) begin
            aod = 1'b0; oe = (n == TP + 1);
        end else if (n <= 2*TP + TG) begin
            cs = 1'b0;
            if (we) begin wr = 1'b0; oe = 1'b1; end
            else    rd = 1'b0;
        end else if (n <= 2*TP + 2*TG) begin
            oe = we && (n == ACK_N);
            if (n == ACK_N) begin
                if (port) a1 = 1'b1;
                else      a0 = 1'b1;
            end
        end else begin
            bsy = 1'b0;
        end
        return {cs, rd, wr, aod, oe, bsy, a0, a1};
    endfunction

    // Walks one whole access from the grant edge; drops both requests at cycle drop_at (0 = never).
    task automatic check_access(input logic port, input logic we, input logic [7:0] addr,
                                input logic [7:0] wdata, input int drop_at);
        logic [7:0] got, exp, exp_b;
        for (int n = 1; n <= OCC; n++) begin
            @(posedge clk);
            @(negedge clk);
            got = {ChipSelect, Read, Write, AoD, bus_oe, busy, ack0, ack1};
            exp = exp_sig(n, we, port);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL pins port=%0d n=%0d got=%b required=%b", port, n, got, exp);
            end
            if (n <= TP + 1 || (we && n > TP + TG && n <= ACK_N)) begin
                exp_b = (n <= TP + 1) ? addr : wdata;
                vectors++;
                if (bus_out !== exp_b) begin
                    miscompares++;
                    $display("FAIL bus_out port=%0d n=%0d got=%h required=%h", port, n, bus_out, exp_b);
                end
            end
            if (n == drop_at) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
    endtask

    task automatic check_idle(input string name);
        logic [7:0] got;
        got = {ChipSelect, Read, Write, AoD, bus_oe, busy, ack0, ack1};
        vectors++;
        if (got !== 8'b1111_0000) begin
            miscompares++;
            $display("FAIL %s_pins got=%b required=11110000", name, got);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        vectors++;
        if (rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rdata got=%h required=00", rdata);
        end
        vectors++;
        if (bus_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_bus_out got=%h required=00", bus_out);
        end
    endtask

    task automatic test_write();
        we0 = 1'b1; addr0 = 8'h21; wdata0 = 8'h45; req0 = 1'b1;
        sb.push_back('{1'b0, model_rdata});
        check_access(1'b0, 1'b1, 8'h21, 8'h45, ACK_N);
    endtask

    task automatic test_read();
        we1 = 1'b0; addr1 = 8'h22; req1 = 1'b1;
        model_rdata = 8'h59;
        sb.push_back('{1'b1, model_rdata});
        check_access(1'b1, 1'b0, 8'h22, 8'h00, ACK_N);
    endtask

    task automatic test_back_to_back();
        we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'hA5; req0 = 1'b1;
        we1 = 1'b0; addr1 = 8'h30; req1 = 1'b1;
        sb.push_back('{1'b0, model_rdata});
        sb.push_back('{1'b1, 8'hA5});
        sb.push_back('{1'b0, 8'hA5});
        sb.push_back('{1'b1, 8'hA5});
        model_rdata = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            check_access(i[0], ~i[0], 8'h30, 8'hA5, (i == 3) ? ACK_N : 0);
        end
    endtask

    task automatic test_reset_mid_write();
        we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h77; req0 = 1'b1;
        for (int n = 1; n <= TP + TG + 3; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        vectors++;
        if ({ChipSelect, Write, AoD} !== 3'b001) begin
            miscompares++;
            $display("FAIL mid_write_data got cs/wr/aod=%b required=001", {ChipSelect, Write, AoD});
        end
        reset = 1'b0;
        req0  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("mid_reset");
        vectors++;
        if (rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset_rdata got=%h required=00", rdata);
        end
        reset = 1'b1;
        model_rdata = 8'h00;
        repeat (OCC) @(posedge clk);
        @(negedge clk);
        check_idle("post_reset");
    endtask

    task automatic test_drop_early();
        we1 = 1'b0; addr1 = 8'h22; req1 = 1'b1;
        model_rdata = 8'h59;
        sb.push_back('{1'b1, model_rdata});
        check_access(1'b1, 1'b0, 8'h22, 8'h00, 3);
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_write();
        test_drop_early();
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_acks got %0d outstanding required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
